branch_flush_ctrl: RTL and testbench
====================================

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 ex_valid  input  1  EX stage holds a real (non-bubble) instruction.
REQ-005 ex_branch  input  1  EX instruction is a conditional branch.
REQ-006 ex_jump  input  1  EX instruction is JAL/JALR (always taken).
REQ-007 ex_taken  input  1  branch-condition result from the branch condition unit.
REQ-008 ex_target  input  32  resolved target address.
REQ-009 fetch_busy  input  1  fetch port cannot accept a PC change this cycle (shared memory busy).
REQ-010 pc_redirect  output  1  PC loads redirect_pc this cycle.
REQ-011 redirect_pc  output  32  target address for the PC mux.
REQ-012 flush_ifid  output  1  squash the IF/ID register this cycle.
REQ-013 flush_idex  output  1  squash the ID/EX register this cycle.
REQ-014 redirect_pend  output  1  a redirect is latched and waiting for fetch_busy to drop.
REQ-015 br_cnt  output  32  count of resolved conditional branches.
REQ-016 tk_cnt  output  32  count of taken redirects (taken branches plus jumps).

Function
REQ-017 Resolve event: ev = ex_valid & (ex_jump | (ex_branch & ex_taken)).
REQ-018 FSM states: IDLE and HOLD; reset state IDLE.
REQ-019 IDLE, ev=1, fetch_busy=0: same cycle (combinational) pc_redirect=1, redirect_pc=ex_target, flush_ifid=1, flush_idex=1; remain IDLE.
REQ-020 IDLE, ev=1, fetch_busy=1: same cycle flush_ifid=1, flush_idex=1, pc_redirect=0; latch ex_target into tgt_q; next state HOLD.
REQ-021 HOLD: flush_ifid=1, flush_idex=1 every cycle; redirect_pend=1; redirect_pc=tgt_q.
REQ-022 HOLD, fetch_busy=0: pc_redirect=1 this cycle; next state IDLE.
REQ-023 HOLD: ev SHALL be ignored (EX holds a squashed bubble); tgt_q is not overwritten.
REQ-024 IDLE, ev=0: all control outputs 0; redirect_pc=tgt_q.
REQ-025 Flush outputs override any external stall; stall has no input here by design.
REQ-026 br_cnt increments by 1 on each cycle with ex_valid & ex_branch in IDLE, whether taken or not; it wraps at 2^32-1 -> 0.
REQ-027 tk_cnt increments by 1 on each cycle with ev in IDLE; it wraps at 2^32-1 -> 0.
REQ-028 Counters are not updated in HOLD.

Reset
REQ-029 rst SHALL force state IDLE, tgt_q=0, br_cnt=0, tk_cnt=0. In that cycle pc_redirect, flush_ifid, flush_idex, and redirect_pend are 0, and redirect_pc is 0.
REQ-030 Reset asserted in HOLD SHALL drop the pending redirect with no pc_redirect pulse.
REQ-031 While rst=1, ev SHALL be ignored and the combinational outputs SHALL be forced to 0.

Structure
REQ-032 State encodings (IDLE=1'b0, HOLD=1'b1) SHALL live in the shared defines file next to the BR_* func3 codes.
REQ-033 Counters SHALL be one sub-module, branch_perf_cnt: two 32-bit wrap counters with inc_br and inc_tk enables.
REQ-034 The FSM, tgt_q, and output decode SHALL reside in branch_flush_ctrl; all flops SHALL be on clk posedge.

Verification
REQ-035 ex_valid=1, ex_branch=1, ex_taken=1, ex_target=0x40, fetch_busy=0 -> same cycle pc_redirect=1, redirect_pc=0x40, both flushes asserted; next cycle br_cnt=1, tk_cnt=1.
REQ-036 ex_branch=1, ex_taken=0 -> no redirect and no flush; br_cnt+1, tk_cnt unchanged.
REQ-037 ex_jump=1, ex_target=0x100, fetch_busy=1 for 3 cycles -> flushes asserted for 4 cycles, redirect_pend for cycles 2-4, pc_redirect=1 only in cycle 4 with redirect_pc=0x100.
REQ-038 In HOLD, a second ev with ex_target=0x200 -> ignored; the eventual redirect_pc is still 0x100; counters unchanged.
REQ-039 rst pulsed during HOLD -> IDLE next cycle, no pc_redirect pulse, counters 0.
REQ-040 Preload br_cnt=0xFFFFFFFF via a 2^32-1 force, then a not-taken branch -> br_cnt=0.

Source files
------------

// File: rtl/branch_flush_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// branch_flush_ctrl_pkg
//   Shared definitions for the EX-stage branch/jump redirect logic: data and
//   counter widths, conditional-branch func3 codes, the redirect FSM state
//   encoding and the packed control bundle driven by the output decoder.
// ----------------------------------------------------------------------------
package branch_flush_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  // Conditional-branch func3 codes (RV32I)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Redirect FSM: IDLE issues redirects directly, HOLD waits on the fetch port
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } redir_state_e;

  // Combinational control bundle produced by the output decoder
  typedef struct packed {
    logic pc_redirect;
    logic flush_ifid;
    logic flush_idex;
    logic redirect_pend;
  } flush_ctrl_t;

  // A control-flow change is resolved in EX: jumps always, branches when taken
  function automatic logic resolve_ev(input logic valid, input logic branch,
                                      input logic jump, input logic taken);
    return valid & (jump | (branch & taken));
  endfunction

endpackage

// File: rtl/branch_flush_ctrl_perf_cnt.sv
// ----------------------------------------------------------------------------
// branch_perf_cnt
//   Two free-running wrap-around event counters for branch statistics.
//   Ports:
//     clk     - rising-edge clock
//     rst     - synchronous active-high reset, clears both counters
//     inc_br  - count one resolved conditional branch this cycle
//     inc_tk  - count one taken redirect this cycle
//     br_cnt  - resolved conditional branch count (wraps to 0)
//     tk_cnt  - taken redirect count (wraps to 0)
// ----------------------------------------------------------------------------
module branch_perf_cnt
  import branch_flush_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_br,
  input  logic             inc_tk,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] tk_q;

  // Branch counter; natural modulo-2^CNT_W wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
    end else if (inc_br) begin
      br_q <= br_q + CNT_W'(1);
    end
  end

  // Taken-redirect counter; natural modulo-2^CNT_W wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      tk_q <= '0;
    end else if (inc_tk) begin
      tk_q <= tk_q + CNT_W'(1);
    end
  end

  assign br_cnt = br_q;
  assign tk_cnt = tk_q;

endmodule

// File: rtl/branch_flush_ctrl.sv
// ----------------------------------------------------------------------------
// branch_flush_ctrl
//   Turns an EX-stage branch/jump resolution into a PC redirect plus IF/ID and
//   ID/EX squash. When the fetch port is busy the target is parked in tgt_q
//   and the FSM holds (flushing every cycle) until the port frees up.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset
//     ex_valid       - EX holds a real instruction
//     ex_branch      - EX instruction is a conditional branch
//     ex_jump        - EX instruction is JAL/JALR
//     ex_taken       - branch condition result
//     ex_target      - resolved target address
//     fetch_busy     - fetch port cannot take a PC change this cycle
//     pc_redirect    - PC loads redirect_pc this cycle (combinational)
//     redirect_pc    - target for the PC mux (combinational)
//     flush_ifid     - squash IF/ID this cycle (combinational)
//     flush_idex     - squash ID/EX this cycle (combinational)
//     redirect_pend  - a parked redirect is waiting on fetch_busy
//     br_cnt, tk_cnt - branch / taken-redirect statistics
// ----------------------------------------------------------------------------
module branch_flush_ctrl
  import branch_flush_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             fetch_busy,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_pend,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  redir_state_e    state_q;
  redir_state_e    state_d;
  logic [XLEN-1:0] tgt_q;
  logic            ev;
  logic            park;
  logic            in_idle;
  flush_ctrl_t     ctrl;

  assign ev      = resolve_ev(ex_valid, ex_branch, ex_jump, ex_taken);
  assign in_idle = (state_q == IDLE) & ~rst;
  // Redirect resolved while fetch cannot accept it: remember the target
  assign park    = in_idle & ev & fetch_busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parked target; untouched in HOLD so a later EX event cannot clobber it
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
    end else if (park) begin
      tgt_q <= ex_target;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (ev && fetch_busy) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!fetch_busy) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode; reset masks every control output and the target
  always_comb begin
    ctrl        = '0;
    redirect_pc = tgt_q;
    if (rst) begin
      redirect_pc = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev) begin
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            if (!fetch_busy) begin
              ctrl.pc_redirect = 1'b1;
              redirect_pc      = ex_target;
            end
          end
        end
        HOLD: begin
          // EX holds a squashed bubble here, so ev is deliberately ignored
          ctrl.flush_ifid    = 1'b1;
          ctrl.flush_idex    = 1'b1;
          ctrl.redirect_pend = 1'b1;
          ctrl.pc_redirect   = ~fetch_busy;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_redirect   = ctrl.pc_redirect;
  assign flush_ifid    = ctrl.flush_ifid;
  assign flush_idex    = ctrl.flush_idex;
  assign redirect_pend = ctrl.redirect_pend;

  // Statistics only advance while IDLE; HOLD cycles carry bubbles
  branch_perf_cnt u_perf_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_br (in_idle & ex_valid & ex_branch),
    .inc_tk (in_idle & ev),
    .br_cnt (br_cnt),
    .tk_cnt (tk_cnt)
  );

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_flush_ctrl
//   Directed vector table, counter wrap sequence, and randomized traffic
//   checked against a queue-based reference model of the redirect behaviour.
// ----------------------------------------------------------------------------
module tb_branch_flush_ctrl;

  localparam bit L = 1'b0;
  localparam bit H = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        fetch_busy;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        redirect_pend;
  logic [31:0] br_cnt;
  logic [31:0] tk_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: outstanding redirects, last parked target, counters
  logic [31:0] m_pend[$];
  logic [31:0] m_last;
  logic [31:0] m_br;
  logic [31:0] m_tk;

  typedef struct {
    bit          rst;
    bit          v;
    bit          b;
    bit          j;
    bit          t;
    logic [31:0] tgt;
    bit          busy;
    bit          e_red;
    logic [31:0] e_pc;
    bit          pc_care;
    bit          e_fl;
    bit          e_pend;
    logic [31:0] e_br;
    logic [31:0] e_tk;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  branch_flush_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .fetch_busy    (fetch_busy),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .redirect_pend (redirect_pend),
    .br_cnt        (br_cnt),
    .tk_cnt        (tk_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit b, input bit j,
                       input bit t, input logic [31:0] tgt, input bit busy);
    rst        = r;
    ex_valid   = v;
    ex_branch  = b;
    ex_jump    = j;
    ex_taken   = t;
    ex_target  = tgt;
    fetch_busy = busy;
  endtask

  task automatic check_all(input bit e_red, input logic [31:0] e_pc, input bit pc_care,
                           input bit e_fl, input bit e_pend,
                           input logic [31:0] e_br, input logic [31:0] e_tk);
    n_vec++;
    chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
    if (pc_care) chk("redirect_pc", redirect_pc, e_pc);
    chk("flush_ifid", 32'(flush_ifid), 32'(e_fl));
    chk("flush_idex", 32'(flush_idex), 32'(e_fl));
    chk("redirect_pend", 32'(redirect_pend), 32'(e_pend));
    chk("br_cnt", br_cnt, e_br);
    chk("tk_cnt", tk_cnt, e_tk);
  endtask

  // One cycle of stimulus checked against the reference model
  task automatic model_cycle(input bit r, input bit v, input bit b, input bit j,
                             input bit t, input logic [31:0] tgt, input bit busy);
    bit          ev;
    bit          e_red;
    bit          e_fl;
    bit          e_pend;
    bit          care;
    logic [31:0] e_pc;
    @(negedge clk);
    drive(r, v, b, j, t, tgt, busy);
    #1;
    ev     = v & (j | (b & t));
    e_red  = 1'b0;
    e_fl   = 1'b0;
    e_pend = 1'b0;
    care   = 1'b1;
    e_pc   = m_last;
    if (r) begin
      e_pc = 32'h0;
    end else if (m_pend.size() != 0) begin
      e_fl   = 1'b1;
      e_pend = 1'b1;
      e_red  = ~busy;
      e_pc   = m_pend[0];
    end else if (ev) begin
      e_fl  = 1'b1;
      e_red = ~busy;
      e_pc  = tgt;
      care  = ~busy;
    end
    check_all(e_red, e_pc, care, e_fl, e_pend, m_br, m_tk);
    if (r) begin
      m_pend.delete();
      m_last = 32'h0;
      m_br   = 32'h0;
      m_tk   = 32'h0;
    end else if (m_pend.size() != 0) begin
      if (!busy) void'(m_pend.pop_front());
    end else begin
      if (v & b) m_br = m_br + 32'd1;
      if (ev)    m_tk = m_tk + 32'd1;
      if (ev & busy) begin
        m_pend.push_back(tgt);
        m_last = tgt;
      end
    end
  endtask

  initial begin
    //          rst v  b  j  t  tgt           busy red pc            care fl pend br     tk
    tbl[0]  = '{H, L, L, L, L, 32'h0,        L,  L,  32'h0,        H,  L, L,  32'd0, 32'd0};
    tbl[1]  = '{L, H, H, L, H, 32'h40,       L,  H,  32'h40,       H,  H, L,  32'd0, 32'd0};
    tbl[2]  = '{L, L, L, L, L, 32'h0,        L,  L,  32'h0,        H,  L, L,  32'd1, 32'd1};
    tbl[3]  = '{L, H, H, L, L, 32'h80,       L,  L,  32'h0,        H,  L, L,  32'd1, 32'd1};
    tbl[4]  = '{L, L, L, L, L, 32'h0,        L,  L,  32'h0,        H,  L, L,  32'd2, 32'd1};
    tbl[5]  = '{L, H, L, H, L, 32'h100,      H,  L,  32'h0,        L,  H, L,  32'd2, 32'd1};
    tbl[6]  = '{L, H, L, H, L, 32'h200,      H,  L,  32'h100,      H,  H, H,  32'd2, 32'd2};
    tbl[7]  = '{L, L, L, L, L, 32'h0,        H,  L,  32'h100,      H,  H, H,  32'd2, 32'd2};
    tbl[8]  = '{L, L, L, L, L, 32'h0,        L,  H,  32'h100,      H,  H, H,  32'd2, 32'd2};
    tbl[9]  = '{L, L, L, L, L, 32'h0,        L,  L,  32'h100,      H,  L, L,  32'd2, 32'd2};
    tbl[10] = '{L, H, L, H, L, 32'h300,      H,  L,  32'h0,        L,  H, L,  32'd2, 32'd2};
    tbl[11] = '{H, H, L, H, L, 32'h500,      L,  L,  32'h0,        H,  L, L,  32'd2, 32'd3};
    tbl[12] = '{L, L, L, L, L, 32'h0,        L,  L,  32'h0,        H,  L, L,  32'd0, 32'd0};

    m_last = 32'h0;
    m_br   = 32'h0;
    m_tk   = 32'h0;
    drive(H, L, L, L, L, 32'h0, L);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].j, tbl[i].t, tbl[i].tgt, tbl[i].busy);
      #1;
      check_all(tbl[i].e_red, tbl[i].e_pc, tbl[i].pc_care, tbl[i].e_fl,
                tbl[i].e_pend, tbl[i].e_br, tbl[i].e_tk);
    end

    // Counter wrap: preload both counters to all-ones, then overflow them
    model_cycle(H, L, L, L, L, 32'h0, L);
    model_cycle(L, L, L, L, L, 32'h0, L);
    force dut.u_perf_cnt.br_q = 32'hFFFF_FFFF;
    force dut.u_perf_cnt.tk_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf_cnt.br_q;
    release dut.u_perf_cnt.tk_q;
    m_br = 32'hFFFF_FFFF;
    m_tk = 32'hFFFF_FFFF;
    model_cycle(L, H, H, L, L, 32'h1234, L);
    model_cycle(L, L, L, L, L, 32'h0, L);
    model_cycle(L, H, L, H, L, 32'h88, L);
    model_cycle(L, L, L, L, L, 32'h0, L);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          v;
      bit          b;
      bit          j;
      bit          t;
      bit          busy;
      logic [31:0] tgt;
      r    = ($urandom_range(0, 39) == 0);
      v    = ($urandom_range(0, 3) != 0);
      b    = 1'($urandom);
      j    = ($urandom_range(0, 3) == 0);
      t    = 1'($urandom);
      busy = 1'($urandom);
      tgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      model_cycle(r, v, b, j, t, tgt, busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
